// File: rtl/bw_r_rf_inq_sweep_if.sv
// Bus bundle for the inbound-queue register file: write, clear, read and observation signals.
interface bw_r_rf_inq_sweep_if #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 2,
  parameter int WDATA_W = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
);
  logic                       wen;
  logic [ADDR_W-1:0]          wr_addr;
  logic [WDATA_W-1:0]         wr_data;
  logic                       wr_drop;
  logic                       clr_req;
  logic                       busy;
  logic                       clr_done;
  logic                       rd_en;
  logic [ADDR_W-1:0]          rd_addr;
  logic [ENTRY_W-1:0]         rd_data;
  logic                       rd_hit;
  logic                       rd_valid;
  logic [DEPTH-1:0]           entry_vld;
  logic [DEPTH*ENTRY_W-1:0]   inq_ary;

  modport slave (
    input  wen, wr_addr, wr_data, clr_req, rd_en, rd_addr,
    output wr_drop, busy, clr_done, rd_data, rd_hit, rd_valid, entry_vld, inq_ary
  );

  modport master (
    output wen, wr_addr, wr_data, clr_req, rd_en, rd_addr,
    input  wr_drop, busy, clr_done, rd_data, rd_hit, rd_valid, entry_vld, inq_ary
  );
endinterface

// File: rtl/bw_r_rf_inq_sweep.sv
// DEPTH x ENTRY_W inbound-queue register file with strided write select,
// per-entry valid bits, bypassing registered read port and a one-entry-per-cycle clear sweep.
//
// state | meaning
// IDLE  | writes accepted, waiting for clr_req
// SWEEP | clearing entry[cnt] each cycle, writes dropped
// DONE  | sweep finished, clr_done high, writes dropped
module bw_r_rf_inq_sweep #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 2,
  parameter int WDATA_W = 8,
  parameter int STRIDE  = 4,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_l,
  bw_r_rf_inq_sweep_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [ENTRY_W-1:0]  ary [DEPTH];
  logic [DEPTH-1:0]    vld;
  logic [ENTRY_W-1:0]  wr_sel;
  logic                wr_ok, rd_ok, sweep_clr;

  assign wr_ok     = bus.wen && (state == IDLE) && ({1'b0, bus.wr_addr} < DEPTH_C);
  assign rd_ok     = bus.rd_en && ({1'b0, bus.rd_addr} < DEPTH_C);
  assign sweep_clr = (state == SWEEP);

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < ENTRY_W; i++) begin
      wr_sel[i] = bus.wr_data[i*STRIDE];
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep and write never coincide: writes are only accepted in IDLE.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      for (int k = 0; k < DEPTH; k++) ary[k] <= '0;
      vld <= '0;
    end else begin
      if (sweep_clr) begin
        ary[cnt] <= '0;
        vld[cnt] <= 1'b0;
      end
      if (wr_ok) begin
        ary[bus.wr_addr] <= wr_sel;
        vld[bus.wr_addr] <= 1'b1;
      end
    end
  end

  // Read returns post-edge contents, so same-edge write/clear are forwarded.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bus.rd_data  <= '0;
      bus.rd_hit   <= 1'b0;
      bus.rd_valid <= 1'b0;
      bus.wr_drop  <= 1'b0;
    end else begin
      bus.rd_valid <= rd_ok;
      bus.wr_drop  <= bus.wen && !wr_ok;
      if (rd_ok) begin
        if (wr_ok && (bus.wr_addr == bus.rd_addr)) begin
          bus.rd_data <= wr_sel;
          bus.rd_hit  <= 1'b1;
        end else if (sweep_clr && (cnt == bus.rd_addr)) begin
          bus.rd_data <= '0;
          bus.rd_hit  <= 1'b0;
        end else begin
          bus.rd_data <= ary[bus.rd_addr];
          bus.rd_hit  <= vld[bus.rd_addr];
        end
      end
    end
  end

  always_comb begin
    bus.inq_ary = '0;
    for (int k = 0; k < DEPTH; k++) begin
      bus.inq_ary[k*ENTRY_W +: ENTRY_W] = ary[k];
    end
  end

  assign bus.entry_vld = vld;
  assign bus.busy      = (state != IDLE);
  assign bus.clr_done  = (state == DONE);

endmodule

// File: tb/tb_bw_r_rf_inq_sweep.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_bw_r_rf_inq_sweep;
  localparam int DEP = 16;

  logic clk = 1'b0;
  logic reset_l = 1'b0;
  always #5 clk = ~clk;

  bw_r_rf_inq_sweep_if #(.DEPTH(16), .ENTRY_W(2), .WDATA_W(8)) bus_a ();
  bw_r_rf_inq_sweep_if #(.DEPTH(12), .ENTRY_W(2), .WDATA_W(8)) bus_b ();

  bw_r_rf_inq_sweep #(.DEPTH(16), .ENTRY_W(2), .WDATA_W(8), .STRIDE(4)) dut_a (
    .clk(clk), .reset_l(reset_l), .bus(bus_a));
  bw_r_rf_inq_sweep #(.DEPTH(12), .ENTRY_W(2), .WDATA_W(8), .STRIDE(4)) dut_b (
    .clk(clk), .reset_l(reset_l), .bus(bus_b));

  int n_chk = 0;
  int n_pass = 0;

  // reference model: entry contents, valid bits, sweep position (-1 idle, DEP = done)
  int m_mem [DEP];
  bit m_vld [DEP];
  int sweep_pos;
  int e_rd, e_hit, e_rv, e_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int sel(input logic [7:0] d);
    return ((int'(d) >> 4) & 1) * 2 + (int'(d) & 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < DEP; k++) begin m_mem[k] = 0; m_vld[k] = 0; end
    sweep_pos = -1;
    e_rd = 0; e_hit = 0; e_rv = 0; e_drop = 0;
  endtask

  task automatic check_all();
    logic [63:0] x_ary, x_vld;
    x_ary = '0; x_vld = '0;
    for (int k = 0; k < DEP; k++) begin
      x_ary = x_ary | (64'(m_mem[k]) << (2*k));
      x_vld = x_vld | (64'(m_vld[k]) << k);
    end
    chk("busy",      64'(bus_a.busy),      64'(sweep_pos >= 0));
    chk("clr_done",  64'(bus_a.clr_done),  64'(sweep_pos == DEP));
    chk("wr_drop",   64'(bus_a.wr_drop),   64'(e_drop));
    chk("rd_valid",  64'(bus_a.rd_valid),  64'(e_rv));
    chk("rd_data",   64'(bus_a.rd_data),   64'(e_rd));
    chk("rd_hit",    64'(bus_a.rd_hit),    64'(e_hit));
    chk("entry_vld", 64'(bus_a.entry_vld), x_vld);
    chk("inq_ary",   64'(bus_a.inq_ary),   x_ary);
  endtask

  task automatic step(input bit wen, input int waddr, input logic [7:0] wdata,
                      input bit clr, input bit ren, input int raddr);
    bit wr_ok;
    @(negedge clk);
    bus_a.wen = wen; bus_a.wr_addr = 4'(waddr); bus_a.wr_data = wdata;
    bus_a.clr_req = clr; bus_a.rd_en = ren; bus_a.rd_addr = 4'(raddr);
    @(posedge clk);
    wr_ok = wen && (sweep_pos < 0) && (waddr < DEP);
    if (sweep_pos >= 0 && sweep_pos < DEP) begin
      m_mem[sweep_pos] = 0; m_vld[sweep_pos] = 0;
    end
    if (wr_ok) begin m_mem[waddr] = sel(wdata); m_vld[waddr] = 1; end
    e_drop = int'(wen && !wr_ok);
    if (ren && raddr < DEP) begin
      e_rd = m_mem[raddr]; e_hit = int'(m_vld[raddr]); e_rv = 1;
    end else e_rv = 0;
    if (sweep_pos < 0) begin
      if (clr) sweep_pos = 0;
    end else if (sweep_pos == DEP) sweep_pos = -1;
    else sweep_pos++;
    #1;
    check_all();
  endtask

  task automatic idle_step();
    step(1'b0, 0, 8'h00, 1'b0, 1'b0, 0);
  endtask

  initial begin
    int n, dn;
    bus_a.wen = 0; bus_a.wr_addr = 0; bus_a.wr_data = 0;
    bus_a.clr_req = 0; bus_a.rd_en = 0; bus_a.rd_addr = 0;
    bus_b.wen = 0; bus_b.wr_addr = 0; bus_b.wr_data = 0;
    bus_b.clr_req = 0; bus_b.rd_en = 0; bus_b.rd_addr = 0;
    model_reset();
    #23;
    check_all();
    @(negedge clk); reset_l = 1'b1;

    // single write with strided select
    step(1'b1, 3, 8'h11, 1'b0, 1'b0, 0);
    chk("t1_vld", 64'(bus_a.entry_vld), 64'h0008);
    chk("t1_ary", 64'(bus_a.inq_ary), 64'h0000_00C0);

    // write/read bypass
    step(1'b1, 5, 8'h10, 1'b0, 1'b1, 5);
    chk("byp_data", 64'(bus_a.rd_data), 64'h2);
    chk("byp_hit",  64'(bus_a.rd_hit), 64'h1);
    chk("byp_rv",   64'(bus_a.rd_valid), 64'h1);

    // fill, sweep with writes hammering every cycle and reading the entry being cleared
    for (int k = 0; k < DEP; k++) step(1'b1, k, 8'($urandom), 1'b0, 1'b1, k);
    step(1'b0, 0, 8'h00, 1'b1, 1'b0, 0);
    n = 0; dn = 0;
    while (bus_a.busy && n < 40) begin
      n++;
      step(1'b1, $urandom_range(0, DEP-1), 8'($urandom), 1'b0, 1'b1, (n-1) % DEP);
      if (bus_a.clr_done) dn++;
    end
    chk("busy_len", 64'(n), 64'd17);
    chk("done_cnt", 64'(dn), 64'd1);
    chk("swp_vld",  64'(bus_a.entry_vld), 64'h0);
    step(1'b1, 9, 8'h11, 1'b0, 1'b0, 0);
    chk("post_wr", 64'(bus_a.entry_vld), 64'h0200);

    // simultaneous write and clear
    step(1'b1, 0, 8'h01, 1'b1, 1'b0, 0);
    chk("sim_e0", 64'(bus_a.inq_ary[1:0]), 64'h1);
    idle_step();
    chk("sim_clr", 64'(bus_a.inq_ary[1:0]), 64'h0);
    n = 0;
    while (bus_a.busy && n < 40) begin n++; idle_step(); end
    chk("sim_idle", 64'(bus_a.busy), 64'h0);

    // reset mid-sweep
    for (int k = 0; k < DEP; k++) step(1'b1, k, 8'($urandom), 1'b0, 1'b0, 0);
    step(1'b0, 0, 8'h00, 1'b1, 1'b1, 2);
    for (int k = 0; k < 7; k++) step(1'b0, 0, 8'h00, 1'b0, 1'b1, k);
    #2 reset_l = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    bus_a.rd_en = 0; bus_a.clr_req = 0; bus_a.wen = 0;
    reset_l = 1'b1;
    for (int k = 0; k < 20; k++) idle_step();

    // DEPTH=12 instance: out-of-range write and read
    @(negedge clk);
    bus_b.wen = 1; bus_b.wr_addr = 4'd13; bus_b.wr_data = 8'hFF;
    @(posedge clk); #1;
    chk("b_drop", 64'(bus_b.wr_drop), 64'h1);
    chk("b_vld0", 64'(bus_b.entry_vld), 64'h0);
    chk("b_ary0", 64'(bus_b.inq_ary), 64'h0);
    @(negedge clk);
    bus_b.wr_addr = 4'd11; bus_b.wr_data = 8'h11; bus_b.rd_en = 1; bus_b.rd_addr = 4'd13;
    @(posedge clk); #1;
    chk("b_nodrop", 64'(bus_b.wr_drop), 64'h0);
    chk("b_vld11",  64'(bus_b.entry_vld), 64'h800);
    chk("b_ary11",  64'(bus_b.inq_ary), 64'hC0_0000);
    chk("b_rv_oor", 64'(bus_b.rd_valid), 64'h0);
    @(negedge clk);
    bus_b.wen = 0; bus_b.rd_addr = 4'd11;
    @(posedge clk); #1;
    chk("b_rdata", 64'(bus_b.rd_data), 64'h3);
    chk("b_rhit",  64'(bus_b.rd_hit), 64'h1);
    chk("b_rv",    64'(bus_b.rd_valid), 64'h1);
    @(negedge clk); bus_b.rd_en = 0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), $urandom_range(0, DEP-1), 8'($urandom),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), $urandom_range(0, DEP-1));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bw_r_rf_inq_sweep.md
# bw_r_rf_inq_sweep

Parametrised successor to the 16x2 inbound-queue register file: a DEPTH x ENTRY_W array written from a wider data bus through a strided bit-select. Adds per-entry valid bits, a registered read port with write bypass, and a sequenced clear (sweep) engine that zeroes one entry per cycle while blocking writes. It sits between the inbound data path and the queue-tracking logic, and it exposes the full array for direct observation.

## Interface
Parameters:
- DEPTH, 16, number of entries (2..256, need not be a power of two)
- ENTRY_W, 2, bits stored per entry
- WDATA_W, 8, write data bus width
- STRIDE, 4, bit spacing of the select: entry bit i = wr_data[i*STRIDE]. Legal only if (ENTRY_W-1)*STRIDE < WDATA_W.
- ADDR_W, $clog2(DEPTH), address width (derived; do not override)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- reset_l  in  1  asynchronous, active-low reset
- wen  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  WDATA_W  write data
- wr_drop  out  1  one-cycle pulse: the write sampled on the previous edge was dropped
- clr_req  in  1  request a sweep clear
- busy  out  1  high while the sweep engine is active
- clr_done  out  1  one-cycle pulse when the sweep completes
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  ENTRY_W  registered read data
- rd_hit  out  1  registered valid bit of the entry that was read
- rd_valid  out  1  high the cycle after an accepted read
- entry_vld  out  DEPTH  per-entry valid bits
- inq_ary  out  DEPTH*ENTRY_W  flattened array; entry k occupies bits [k*ENTRY_W +: ENTRY_W]

## Operation
- Reset (reset_l low, asynchronous): all entries are 0, entry_vld is 0, the FSM is in IDLE, and the sweep counter is 0. Reset drives wr_drop, busy, clr_done, rd_data, rd_hit and rd_valid to 0. Reset asserted mid-sweep aborts the sweep immediately.
- FSM states:
  - IDLE -> SWEEP when clr_req=1.
  - SWEEP: the counter cnt runs 0..DEPTH-1. Each edge clears entry[cnt] and entry_vld[cnt], then increments cnt. The edge that clears entry DEPTH-1 moves the FSM to DONE.
  - DONE -> IDLE unconditionally.
- Writes:
  - Accepted when wen=1, the state is IDLE and wr_addr < DEPTH. On acceptance, entry[wr_addr] takes the strided select of wr_data and entry_vld[wr_addr] is set to 1.
  - wen=1 in SWEEP or DONE, or with wr_addr >= DEPTH, is dropped. The array is unchanged and wr_drop pulses in the next cycle.
- Simultaneous wen and clr_req in IDLE: the write is performed at that edge and the FSM enters SWEEP. The written entry is cleared later by the sweep.
- clr_req in SWEEP or DONE is ignored. There is no queuing of clear requests.
- Reads:
  - Accepted whenever rd_en=1 and rd_addr < DEPTH, in any state.
  - rd_data and rd_hit are taken from array contents after the same edge's update. A same-cycle accepted write to rd_addr is therefore bypassed (new data, rd_hit=1). A same-cycle sweep clear of rd_addr returns 0 with rd_hit=0.
  - An out-of-range rd_addr gives rd_valid=0; rd_data and rd_hit hold their previous values.

## Timing
- Write latency: inq_ary and entry_vld reflect the write 1 cycle after the sampling edge.
- Read latency: rd_data, rd_hit and rd_valid are valid 1 cycle after rd_en is sampled. rd_valid is a single-cycle pulse per accepted read; back-to-back reads are supported at full rate.
- Sweep, with clr_req sampled at edge E0:
  - busy rises after E0.
  - Entry k is cleared at edge E0+1+k.
  - The FSM enters DONE at E0+DEPTH, and clr_done is high for the following cycle.
  - The FSM returns to IDLE at E0+DEPTH+1.
  - busy is therefore high for exactly DEPTH+1 cycles. A write presented in the first cycle with busy=0 is accepted.
- wr_drop: high for exactly 1 cycle per dropped write; consecutive drops give consecutive pulses.

## Test plan
- Reset, then write wr_addr=3, wr_data=8'h11 (DEFAULT params) -> next cycle entry 3 = 2'b11, entry_vld=16'h0008, all other entries 0.
- Write addr 5 data 8'h10 with rd_en=1, rd_addr=5 in the same cycle -> next cycle rd_data=2'b10, rd_hit=1, rd_valid=1.
- Fill all 16 entries, then pulse clr_req -> busy high for 17 cycles, entry k reads 0 from edge E0+1+k, clr_done pulses once, entry_vld=0 at the end.
- wen=1 on every cycle during the sweep -> wr_drop pulses every cycle, array remains 0 after DONE, and the first write after busy falls is accepted.
- Same-cycle wen (addr 0, data 8'h01) and clr_req -> entry 0 = 2'b01 for one cycle, then cleared at E0+1.
- Assert reset_l mid-sweep (cnt=7) -> outputs and state go to reset values asynchronously; no clr_done pulse. Also DEPTH=12, write addr 13 -> dropped with a wr_drop pulse.
